// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, FSM states, default datapath width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // Same encodings the ALU decoder emits on ALU_control.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MULT = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULDIV = 2'd1,
        FINISH = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed mult (shift-add) / div (restoring) on operand magnitudes, sign fixed at the output.
// Latency: WIDTH step_en cycles after start; last flags the final step.
// Backpressure: none; steps only while step_en is high, operands latched on start.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_div,
    input  logic             step_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      count;
    logic               div_op;
    logic               neg_lo;
    logic               neg_hi;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic [WIDTH:0]     step_sum;
    logic [WIDTH:0]     step_shift;
    logic [WIDTH:0]     step_diff;
    logic [WIDTH:0]     nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod;

    assign a_mag_in = a[WIDTH-1] ? -a : a;
    assign b_mag_in = b[WIDTH-1] ? -b : b;
    assign last     = (count == CW'(WIDTH - 1));

    always_comb begin
        step_sum   = acc_lo[0] ? (acc_hi + {1'b0, b_mag}) : acc_hi;
        step_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        step_diff  = step_shift - {1'b0, b_mag};
        nxt_hi     = {1'b0, step_sum[WIDTH:1]};
        nxt_lo     = {step_sum[0], acc_lo[WIDTH-1:1]};
        if (div_op) begin
            // Borrow out of the trial subtract means the divisor did not fit.
            if (step_diff[WIDTH]) begin
                nxt_hi = step_shift;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                nxt_hi = step_diff;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc_hi <= '0;
            acc_lo <= '0;
            b_mag  <= '0;
            count  <= '0;
            div_op <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
        end else if (start) begin
            acc_hi <= '0;
            acc_lo <= a_mag_in;
            b_mag  <= b_mag_in;
            count  <= '0;
            div_op <= is_div;
            neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi <= is_div & a[WIDTH-1];
        end else if (step_en) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            count  <= count + CW'(1);
        end
    end

    always_comb begin
        prod = {acc_hi[WIDTH-1:0], acc_lo};
        if (neg_lo) begin
            prod = -prod;
        end
        hi = prod[2*WIDTH-1:WIDTH];
        lo = prod[WIDTH-1:0];
        if (div_op) begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo = neg_lo ? -acc_lo : acc_lo;
            hi = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle ops plus iterative signed mult/div into HI/LO.
// Latency: 1 cycle for single-cycle ops and div-by-zero, WIDTH+2 cycles for mult/div.
// Backpressure: Start is ignored while Busy; a Start during the Done cycle is accepted.
module alu_execute_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             Start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             Div_by_zero
);

    alu_state_t       state;
    alu_state_t       state_nxt;
    logic             accept;
    logic             div_zero;
    logic             muldiv_go;
    logic             seq_last;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] seq_hi;
    logic [WIDTH-1:0] seq_lo;

    assign accept    = (state == IDLE) && Start;
    assign div_zero  = (ALU_control == ALU_DIV) && (B == '0);
    assign muldiv_go = accept && ((ALU_control == ALU_MULT) ||
                                  ((ALU_control == ALU_DIV) && !div_zero));
    assign Busy      = (state != IDLE);

    always_comb begin
        alu_res = '0;
        case (ALU_control)
            ALU_ADD: alu_res = A + B;
            ALU_SUB: alu_res = A - B;
            ALU_SLL: alu_res = B << Shamt;
            ALU_SRL: alu_res = B >> Shamt;
            ALU_AND: alu_res = A & B;
            ALU_OR:  alu_res = A | B;
            ALU_XOR: alu_res = A ^ B;
            ALU_NOR: alu_res = ~(A | B);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (muldiv_go) state_nxt = MULDIV;
            MULDIV:  if (seq_last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            Result      <= '0;
            Zero        <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            Done        <= 1'b0;
            Div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= 1'b0;
            if (accept) begin
                Div_by_zero <= div_zero;
                if (div_zero) begin
                    HI     <= A;
                    LO     <= '1;
                    Result <= '1;
                    Zero   <= 1'b0;
                    Done   <= 1'b1;
                end else if (!muldiv_go) begin
                    Result <= alu_res;
                    Zero   <= (alu_res == '0);
                    Done   <= 1'b1;
                end
            end
            if (state == FINISH) begin
                HI     <= seq_hi;
                LO     <= seq_lo;
                Result <= seq_lo;
                Zero   <= (seq_lo == '0);
                Done   <= 1'b1;
            end
        end
    end

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clock   (clock),
        .resetn  (resetn),
        .start   (muldiv_go),
        .is_div  (ALU_control == ALU_DIV),
        .step_en (state == MULDIV),
        .a       (A),
        .b       (B),
        .last    (seq_last),
        .hi      (seq_hi),
        .lo      (seq_lo)
    );

endmodule

// File: tb/tb_alu_execute_unit.sv
// Scoreboard bench for alu_execute_unit: directed cases then random ops against a signed-arithmetic model.
module tb_alu_execute_unit;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  ALU_control = 4'h0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic [4:0]  Shamt = 5'h0;
    logic [31:0] Result, HI, LO;
    logic        Zero, Busy, Done, Div_by_zero;

    alu_execute_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .Start       (Start),
        .ALU_control (ALU_control),
        .A           (A),
        .B           (B),
        .Shamt       (Shamt),
        .Result      (Result),
        .Zero        (Zero),
        .HI          (HI),
        .LO          (LO),
        .Busy        (Busy),
        .Done        (Done),
        .Div_by_zero (Div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          busy;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: plain signed arithmetic; HI/LO persist across ops.
    function automatic exp_t predict(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint pa, pb, p;
        int     sa, sbv;
        e.res = 32'h0;
        e.dbz = 1'b0;
        e.busy = 0;
        case (op)
            4'b0000: e.res = a + b;
            4'b0001: e.res = a - b;
            4'b0100: e.res = b << sh;
            4'b0101: e.res = b >> sh;
            4'b1000: e.res = a & b;
            4'b1001: e.res = a | b;
            4'b1010: e.res = a ^ b;
            4'b1011: e.res = ~(a | b);
            4'b0010: begin
                pa = $signed(a);
                pb = $signed(b);
                p = pa * pb;
                hi_m = p[63:32];
                lo_m = p[31:0];
                e.res = lo_m;
                e.busy = 33;
            end
            4'b0011: begin
                if (b == 32'h0) begin
                    hi_m = a;
                    lo_m = 32'hFFFFFFFF;
                    e.dbz = 1'b1;
                end else begin
                    e.busy = 33;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                        lo_m = 32'h80000000;
                        hi_m = 32'h0;
                    end else begin
                        sa = a;
                        sbv = b;
                        lo_m = sa / sbv;
                        hi_m = sa % sbv;
                    end
                end
                e.res = lo_m;
            end
            default: e.res = 32'h0;
        endcase
        e.zero = (e.res == 32'h0);
        e.hi = hi_m;
        e.lo = lo_m;
        return e;
    endfunction

    // Issue one op (called at a negedge) and wait for its Done; poke>0 pulses a stray Start mid-op.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int poke);
        int n;
        exp_q.push_back(predict(op, a, b, sh));
        ALU_control = op;
        A = a;
        B = b;
        Shamt = sh;
        Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (poke != 0 && n == poke) begin
                Start = 1'b1;
                ALU_control = 4'b0000;
                A = $urandom;
                B = $urandom;
            end
            @(negedge clock);
            Start = 1'b0;
            n++;
        end
        if (Done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: op %b got no Done within %0d cycles", op, n);
        end
    endtask

    function automatic logic [31:0] rv();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = $urandom_range(0, 20);
            4: v = 32'(0 - $urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: pops one expectation per Done pulse and measures the preceding Busy run.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clock);
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Result=%h with no op outstanding", Result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", Result, e.res);
                    chk("zero", 32'(Zero), 32'(e.zero));
                    chk("hi", HI, e.hi);
                    chk("lo", LO, e.lo);
                    chk("div_by_zero", 32'(Div_by_zero), 32'(e.dbz));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                end
                busy_cnt = 0;
            end else if (Busy === 1'b1) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] codes [14];
        codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB,
                  4'h6, 4'h7, 4'hC, 4'hF};

        resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_result", Result, 32'h0);
        chk("rst_zero", 32'(Zero), 32'h0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_dbz", 32'(Div_by_zero), 32'h0);
        resetn = 1'b1;

        do_op(4'b0000, 32'd7, 32'd5, 5'd0, 0);
        do_op(4'b0001, 32'd5, 32'd5, 5'd0, 0);
        do_op(4'b0010, 32'hFFFFFFFD, 32'd7, 5'd0, 0);
        do_op(4'b0011, 32'hFFFFFFF9, 32'd2, 5'd0, 0);
        do_op(4'b0011, 32'd9, 32'd0, 5'd0, 0);
        do_op(4'b0100, 32'd0, 32'd1, 5'd4, 0);
        do_op(4'b0101, 32'd0, 32'h80000000, 5'd31, 0);
        do_op(4'b0110, 32'd3, 32'd4, 5'd0, 0);
        do_op(4'b0010, 32'd6, 32'd7, 5'd0, 5);
        do_op(4'b0011, 32'h80000000, 32'hFFFFFFFF, 5'd0, 0);
        do_op(4'b0011, 32'd7, 32'hFFFFFFFE, 5'd0, 0);

        // Reset in the middle of a div: no Done, everything cleared.
        ALU_control = 4'b0011;
        A = 32'd100;
        B = 32'd7;
        Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        repeat (9) @(negedge clock);
        chk("busy_mid_div", 32'(Busy), 32'h1);
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_result", Result, 32'h0);
        chk("abort_zero", 32'(Zero), 32'h0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        chk("abort_busy", 32'(Busy), 32'h0);
        chk("abort_done", 32'(Done), 32'h0);
        chk("abort_dbz", 32'(Div_by_zero), 32'h0);
        resetn = 1'b1;
        hi_m = 32'h0;
        lo_m = 32'h0;
        do_op(4'b0000, 32'd1, 32'd1, 5'd0, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(codes[$urandom_range(0, 13)], rv(), rv(), 5'($urandom_range(0, 31)), 0);
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
